wb_fifo_slave: RTL and testbench

Wishbone classic slave exposing a memory-mapped transmit mailbox. Bus writes push 32-bit words into an internal FIFO. A hardware consumer drains the FIFO through a valid/ready stream port. The block hangs off the SoC interconnect as an additional slave; the interconnect has already stripped the upper slave-select nibble, so the block sees a 12-bit offset.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo_slave_if.sv | 30 +++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/wb_fifo_slave.sv | 163 ++++++++++++++++
 tb/tb_wb_fifo_slave.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - register map, bit positions and FSM state type for the mailbox slave
package wb_pkg;

  localparam int WB_DATA_WIDTH = 32;

  // Byte offsets; only adr_i[3:2] is decoded.
  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL  = 17;
  localparam int STAT_OVF   = 18;
  localparam int STAT_UDF   = 19;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_t;

endpackage

// File: rtl/wb_fifo_slave_if.sv
// rtl/wb_fifo_slave_if.sv - Wishbone classic bus plus outbound stream of the mailbox slave
interface wb_fifo_slave_if
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = 12
);
  logic                    cyc_i;
  logic                    stb_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [DATA_WIDTH/8-1:0] sel_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    ack_o;
  logic                    err_o;
  logic                    m_valid;
  logic                    m_ready;
  logic [DATA_WIDTH-1:0]   m_data;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, m_ready,
    output dat_o, ack_o, err_o, m_valid, m_data
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, m_ready,
    input  dat_o, ack_o, err_o, m_valid, m_data
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with pre-edge full check and flush
module sync_fifo
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign head      = r_mem[r_rptr];
  assign count     = r_count;

  // Storage carries no reset; contents are meaningless until counted.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end
endmodule

// File: rtl/wb_fifo_slave.sv
// rtl/wb_fifo_slave.sv - Wishbone classic slave pushing bus writes into a FIFO drained by a stream port
module wb_fifo_slave
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_fifo_slave_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  bus_state_t            r_state;
  bus_state_t            w_state_n;
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_req;
  logic [3:0]            w_off;
  logic                  w_addr_hi_zero;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_clr;
  logic                  w_set_ovf;
  logic                  w_set_udf;
  logic                  w_ack_n;
  logic                  w_err_n;
  logic [DATA_WIDTH-1:0] w_dat_n;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_head;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_unused_adr;

  assign w_req          = bus.cyc_i & bus.stb_i;
  assign w_off          = {bus.adr_i[3:2], 2'b00};
  assign w_addr_hi_zero = (bus.adr_i[ADDR_WIDTH-1:4] == '0);
  assign w_unused_adr   = ^bus.adr_i[1:0];
  assign w_pop          = ~w_empty & bus.m_ready;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (w_push),
    .push_data (bus.dat_i),
    .pop       (w_pop),
    .flush     (w_flush),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    w_status             = '0;
    w_status[15:0]       = 16'(w_count);
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_OVF]   = r_ovf;
    w_status[STAT_UDF]   = r_udf;
  end

  // Every side effect happens on the IDLE sampling edge; RESP only holds the response.
  always_comb begin
    w_state_n = r_state;
    w_push    = 1'b0;
    w_flush   = 1'b0;
    w_clr     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_udf = 1'b0;
    w_ack_n   = 1'b0;
    w_err_n   = 1'b0;
    w_dat_n   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_n = ST_RESP;
          if (!w_addr_hi_zero) begin
            w_err_n = 1'b1;
          end else begin
            case (w_off)
              REG_DATA: begin
                if (bus.we_i) begin
                  if (!(&bus.sel_i)) begin
                    w_err_n = 1'b1;
                  end else if (w_full) begin
                    w_err_n   = 1'b1;
                    w_set_ovf = 1'b1;
                  end else begin
                    w_ack_n = 1'b1;
                    w_push  = 1'b1;
                  end
                end else if (w_empty) begin
                  w_err_n   = 1'b1;
                  w_set_udf = 1'b1;
                end else begin
                  w_ack_n = 1'b1;
                  w_dat_n = w_head;
                end
              end
              REG_STATUS: begin
                w_ack_n = 1'b1;
                if (!bus.we_i) begin
                  w_dat_n = w_status;
                end
              end
              REG_CTRL: begin
                w_ack_n = 1'b1;
                if (bus.we_i) begin
                  w_flush = bus.dat_i[CTRL_FLUSH];
                  w_clr   = bus.dat_i[CTRL_CLR];
                end
              end
              default: begin
                w_err_n = 1'b1;
              end
            endcase
          end
        end
      end
      ST_RESP: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ack   <= w_ack_n;
      r_err   <= w_err_n;
      r_dat   <= w_dat_n;
      r_ovf   <= w_clr ? 1'b0 : (r_ovf | w_set_ovf);
      r_udf   <= w_clr ? 1'b0 : (r_udf | w_set_udf);
    end
  end

  assign bus.ack_o   = r_ack;
  assign bus.err_o   = r_err;
  assign bus.dat_o   = r_dat;
  assign bus.m_valid = ~w_empty;
  assign bus.m_data  = w_head;
endmodule

// File: tb/tb_wb_fifo_slave.sv
// tb/tb_wb_fifo_slave.sv - directed self-checking bench for wb_fifo_slave
module tb_wb_fifo_slave;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_fifo_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

  wb_fifo_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12),
    .DEPTH      (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic        t_ack, t_err, t_mv, t_ack2, t_err2, t_mv2;
  logic [31:0] t_dat, t_md;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request for edge N, snapshot after N and after N+1.
  task automatic xfer(input logic we, input logic [11:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = adr;
    bus.sel_i = sel;
    bus.dat_i = dat;
    @(posedge clk);
    #1;
    t_ack = bus.ack_o;
    t_err = bus.err_o;
    t_dat = bus.dat_o;
    t_mv  = bus.m_valid;
    t_md  = bus.m_data;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    @(posedge clk);
    #1;
    t_ack2 = bus.ack_o;
    t_err2 = bus.err_o;
    t_mv2  = bus.m_valid;
  endtask

  task automatic status_is(input string tag, input logic [31:0] exp);
    xfer(1'b0, 12'h004, 4'hF, 32'h0);
    check({tag, "_ack"}, 32'(t_ack), 32'd1);
    check(tag, t_dat, exp);
  endtask

  task automatic push_ok(input string tag, input logic [31:0] dat);
    xfer(1'b1, 12'h000, 4'hF, dat);
    check(tag, {30'd0, t_err, t_ack}, 32'd1);
  endtask

  initial begin
    int acks;
    bus.cyc_i   = 1'b0;
    bus.stb_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.adr_i   = '0;
    bus.sel_i   = '0;
    bus.dat_i   = '0;
    bus.m_ready = 1'b0;

    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_dat", bus.dat_o, 32'd0);
    check("rst_mvalid", 32'(bus.m_valid), 32'd0);
    rst = 1'b0;

    status_is("rst_status", 32'h0001_0000);
    check("ack_pulse_drop", {30'd0, t_err2, t_ack2}, 32'd0);

    acks = 0;
    for (int i = 1; i <= 8; i++) begin
      xfer(1'b1, 12'h000, 4'hF, 32'h11 * i);
      if (t_ack && !t_err) acks++;
    end
    check("fill_acks", 32'(acks), 32'd8);
    status_is("full_status", 32'h0002_0008);
    xfer(1'b1, 12'h000, 4'hF, 32'h99);
    check("ovf_resp", {30'd0, t_err, t_ack}, 32'd2);
    status_is("ovf_status", 32'h0006_0008);
    xfer(1'b0, 12'h000, 4'hF, 32'h0);
    check("peek_head", t_dat, 32'h11);

    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", 32'(bus.m_valid), 32'd1);
      check("drain_data", bus.m_data, 32'h11 * i);
      @(posedge clk);
      #1;
    end
    check("drained_valid", 32'(bus.m_valid), 32'd0);
    bus.m_ready = 1'b0;
    status_is("drained_status", 32'h0005_0000);

    xfer(1'b0, 12'h000, 4'hF, 32'h0);
    check("udf_resp", {30'd0, t_err, t_ack}, 32'd2);
    check("udf_dat", t_dat, 32'd0);
    status_is("udf_status", 32'h000D_0000);
    xfer(1'b1, 12'h008, 4'hF, 32'h2);
    check("clr_ack", {30'd0, t_err, t_ack}, 32'd1);
    status_is("clr_status", 32'h0001_0000);

    bus.m_ready = 1'b1;
    check("pass_pre_valid", 32'(bus.m_valid), 32'd0);
    push_ok("pass_push", 32'hDEAD_BEEF);
    check("pass_valid", 32'(t_mv), 32'd1);
    check("pass_data", t_md, 32'hDEAD_BEEF);
    check("pass_valid_gone", 32'(t_mv2), 32'd0);
    status_is("pass_status", 32'h0001_0000);
    bus.m_ready = 1'b0;

    push_ok("fl_push_a", 32'hA);
    push_ok("fl_push_b", 32'hB);
    push_ok("fl_push_c", 32'hC);
    status_is("fl_pre_status", 32'h0000_0003);
    bus.m_ready = 1'b1;
    xfer(1'b1, 12'h008, 4'hF, 32'h1);
    check("fl_ack", {30'd0, t_err, t_ack}, 32'd1);
    check("fl_valid", 32'(t_mv), 32'd0);
    check("fl_valid2", 32'(t_mv2), 32'd0);
    bus.m_ready = 1'b0;
    status_is("fl_status", 32'h0001_0000);

    xfer(1'b0, 12'h00C, 4'hF, 32'h0);
    check("rsvd_resp", {30'd0, t_err, t_ack}, 32'd2);
    xfer(1'b1, 12'h100, 4'hF, 32'h5);
    check("hiaddr_resp", {30'd0, t_err, t_ack}, 32'd2);
    push_ok("sel_push", 32'h77);
    xfer(1'b1, 12'h000, 4'b0011, 32'h88);
    check("sel_resp", {30'd0, t_err, t_ack}, 32'd2);
    status_is("sel_status", 32'h0000_0001);

    push_ok("rst_push_a", 32'h1);
    push_ok("rst_push_b", 32'h2);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b1;
    bus.adr_i = 12'h000;
    bus.sel_i = 4'hF;
    bus.dat_i = 32'h3;
    @(posedge clk);
    #1;
    check("mid_ack", 32'(bus.ack_o), 32'd1);
    rst = 1'b1;
    #3;
    check("mid_rst_ack", 32'(bus.ack_o), 32'd0);
    check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_resp", {30'd0, bus.err_o, bus.ack_o}, 32'd0);
    status_is("post_rst_status", 32'h0001_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
